// File: rtl/input_dequantizer.sv
// rtl/input_dequantizer.sv - int8 activation to accumulator-domain dequantizer, 3-stage valid/ready pipe
// Optional build macro DEQUANT_ROUND_EN: round half toward +inf instead of floor in the final shift.
module input_dequantizer #(
  parameter int inputWidth     = 8,
  parameter int outputWidth    = 20,
  parameter int fixedPointBits = 16,
  parameter int shiftBits      = 4
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [inputWidth-1:0]     x_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [outputWidth-1:0]    wx_o,
  input  logic                      cfg_load,
  input  logic [fixedPointBits-1:0] cfg_scale,
  input  logic [shiftBits-1:0]      cfg_shift,
  input  logic [inputWidth-1:0]     cfg_zp,
  output logic                      busy
);

  localparam int DW = inputWidth + 1;
  localparam int PW = inputWidth + fixedPointBits + 1;
  localparam int QW = inputWidth + fixedPointBits + (1 << shiftBits) + 1;
  localparam int HW = QW - outputWidth + 1;

  typedef enum logic [0:0] {RUN, DRAIN} state_t;

  state_t                    state, state_nx;
  logic [fixedPointBits-1:0] scale, scale_nx, sh_scale, sh_scale_nx;
  logic [shiftBits-1:0]      shift, shift_nx, sh_shift, sh_shift_nx;
  logic [inputWidth-1:0]     zp, zp_nx, sh_zp, sh_zp_nx;

  logic                      v0, v1, v2;
  logic signed [DW-1:0]      d0;
  logic signed [PW-1:0]      p1;
  logic [outputWidth-1:0]    wx2;

  logic                      adv, accept;
  logic signed [DW-1:0]      d_c;
  logic [DW-1:0]             mag;
  logic [PW-1:0]             prod;
  logic [PW-1:0]             p_c;
  logic signed [QW-1:0]      pext, shl, q;
  logic [HW-1:0]             hi;
  logic [outputWidth-1:0]    wx_c;

  assign adv       = !v2 || out_ready;
  assign busy      = v0 || v1 || v2;
  assign in_ready  = !nrst && adv && (state == RUN);
  assign accept    = in_valid && in_ready;
  assign out_valid = v2;
  assign wx_o      = wx2;

  always_comb begin
    state_nx    = state;
    scale_nx    = scale;
    shift_nx    = shift;
    zp_nx       = zp;
    sh_scale_nx = sh_scale;
    sh_shift_nx = sh_shift;
    sh_zp_nx    = sh_zp;
    unique case (state)
      RUN: begin
        if (cfg_load) begin
          if (!busy) begin
            scale_nx = cfg_scale;
            shift_nx = cfg_shift;
            zp_nx    = cfg_zp;
          end else begin
            sh_scale_nx = cfg_scale;
            sh_shift_nx = cfg_shift;
            sh_zp_nx    = cfg_zp;
            state_nx    = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (cfg_load) begin
          sh_scale_nx = cfg_scale;
          sh_shift_nx = cfg_shift;
          sh_zp_nx    = cfg_zp;
        end
        if (!busy) begin
          state_nx = RUN;
          scale_nx = cfg_load ? cfg_scale : sh_scale;
          shift_nx = cfg_load ? cfg_shift : sh_shift;
          zp_nx    = cfg_load ? cfg_zp    : sh_zp;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  // zp_nx carries a same-cycle load on an idle pipe, so that sample already sees the new zero point.
  always_comb begin
    d_c  = $signed({x_i[inputWidth-1], x_i}) - $signed({zp_nx[inputWidth-1], zp_nx});
    mag  = d0[DW-1] ? -d0 : d0;
    prod = {{fixedPointBits{1'b0}}, mag} * {{DW{1'b0}}, scale};
    p_c  = d0[DW-1] ? -prod : prod;
  end

  always_comb begin
    pext = {{(QW-PW){p1[PW-1]}}, p1};
`ifdef DEQUANT_ROUND_EN
    shl  = (pext <<< shift) + (QW'(1) <<< (fixedPointBits - 1));
`else
    shl  = pext <<< shift;
`endif
    q    = shl >>> fixedPointBits;
    hi   = q[QW-1:outputWidth-1];
    if (hi == {HW{q[QW-1]}}) begin
      wx_c = q[outputWidth-1:0];
    end else if (q[QW-1]) begin
      wx_c = {1'b1, {(outputWidth-1){1'b0}}};
    end else begin
      wx_c = {1'b0, {(outputWidth-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state    <= RUN;
      scale    <= '0;
      shift    <= '0;
      zp       <= '0;
      sh_scale <= '0;
      sh_shift <= '0;
      sh_zp    <= '0;
      v0       <= 1'b0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      d0       <= '0;
      p1       <= '0;
      wx2      <= '0;
    end else begin
      state    <= state_nx;
      scale    <= scale_nx;
      shift    <= shift_nx;
      zp       <= zp_nx;
      sh_scale <= sh_scale_nx;
      sh_shift <= sh_shift_nx;
      sh_zp    <= sh_zp_nx;
      if (adv) begin
        v0 <= accept;
        v1 <= v0;
        v2 <= v1;
        if (accept) d0  <= d_c;
        if (v0)     p1  <= $signed(p_c);
        if (v1)     wx2 <= wx_c;
      end
    end
  end

endmodule

// File: tb/tb_input_dequantizer.sv
// tb/tb_input_dequantizer.sv - directed bench with arithmetic reference model for input_dequantizer
module tb_input_dequantizer;

  logic               clk = 1'b0;
  logic               nrst;
  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  x_i;
  logic               out_valid;
  logic               out_ready;
  logic [19:0]        wx_o;
  logic               cfg_load;
  logic [15:0]        cfg_scale;
  logic [3:0]         cfg_shift;
  logic signed [7:0]  cfg_zp;
  logic               busy;

  int checks = 0;
  int failures = 0;

  input_dequantizer dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready), .x_i(x_i),
    .out_valid(out_valid), .out_ready(out_ready), .wx_o(wx_o), .cfg_load(cfg_load),
    .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int dq(input int x, input int zp, input int scale, input int sh);
    longint t;
    t = longint'(x - zp) * longint'(scale) * (longint'(1) << sh);
`ifdef DEQUANT_ROUND_EN
    t = t + 32768;
`endif
    t = t >>> 16;
    if (t > 524287) t = 524287;
    if (t < -524288) t = -524288;
    return int'(t);
  endfunction

  // Reference model: expected results queued at acceptance, checked as they leave.
  int  exp_q[$];
  int  acc_q[$];
  int  out_log[$];
  int  cyc = 0;
  bit  stall_prev = 0;
  logic [19:0] wx_prev;
  bit  lat_check = 0;
  int  m_scale = 0, m_shift = 0, m_zp = 0;
  bit  was_busy;
  int  s_scale, s_shift, s_zp, a_cyc;

  always @(negedge clk) begin
    cyc++;
    if (nrst) begin
      exp_q.delete();
      acc_q.delete();
      m_scale = 0; m_shift = 0; m_zp = 0;
      stall_prev = 0;
    end else begin
      was_busy = (exp_q.size() != 0);
      chk("busy_vs_model", busy, was_busy);
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", wx_o, wx_prev);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else if (out_ready) begin
          chk("wx_vs_model", $signed(wx_o), exp_q.pop_front());
          a_cyc = acc_q.pop_front();
          if (lat_check) chk("latency", cyc - a_cyc, 3);
          out_log.push_back(int'($signed(wx_o)));
        end
      end
      s_scale = (cfg_load && !was_busy) ? int'(cfg_scale) : m_scale;
      s_shift = (cfg_load && !was_busy) ? int'(cfg_shift) : m_shift;
      s_zp    = (cfg_load && !was_busy) ? int'(cfg_zp)    : m_zp;
      if (cfg_load) begin
        m_scale = int'(cfg_scale); m_shift = int'(cfg_shift); m_zp = int'(cfg_zp);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(dq(int'(x_i), s_zp, s_scale, s_shift));
        acc_q.push_back(cyc);
      end
      stall_prev = out_valid && !out_ready;
      wx_prev = wx_o;
    end
  end

  task automatic set_cfg(input int s, input int sh, input int z);
    cfg_scale = s[15:0];
    cfg_shift = sh[3:0];
    cfg_zp    = z[7:0];
  endtask

  task automatic pulse_load();
    cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic send(input int x, input bit load);
    bit acc;
    int n;
    in_valid = 1'b1;
    x_i = x[7:0];
    cfg_load = load;
    n = 0;
    acc = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      cfg_load = 1'b0;
      n++;
    end while (!acc && n < 100);
    in_valid = 1'b0;
    chk("send_accept", acc, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_idle", busy, 0);
  endtask

  task automatic log_at(input string name, input int idx, input int expv);
    if (idx < out_log.size()) chk(name, out_log[idx], expv);
    else chk({name, "_missing"}, out_log.size(), idx + 1);
  endtask

  int base, sent, tmp;
  bit blocked, got;
  int vals[8];

  initial begin
    nrst = 1'b1; in_valid = 1'b0; x_i = '0; out_ready = 1'b1;
    cfg_load = 1'b0; cfg_scale = '0; cfg_shift = '0; cfg_zp = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    @(posedge clk); #1;
    nrst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_wx", wx_o, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready_after", in_ready, 1);
    @(posedge clk); #1;

    chk("model_pin_t2", dq(100, -28, 32768, 3), 512);
    chk("model_pin_sat_hi", dq(127, -128, 65535, 15), 524287);
    chk("model_pin_sat_lo", dq(-128, 127, 65535, 15), -524288);

    // T1: identity mapping, back-to-back, fixed latency
    set_cfg(32'h8000, 1, 0);
    pulse_load();
    lat_check = 1;
    base = out_log.size();
    send(-128, 0); send(-1, 0); send(0, 0); send(127, 0);
    drain();
    log_at("t1_m128", base, -128);
    log_at("t1_m1", base + 1, -1);
    log_at("t1_0", base + 2, 0);
    log_at("t1_127", base + 3, 127);

    // T2: same-cycle config with sample, saturation both ways
    base = out_log.size();
    set_cfg(32'h8000, 3, -28);   send(100, 1);  drain();
    set_cfg(32'hFFFF, 15, -128); send(127, 1);  drain();
    set_cfg(32'hFFFF, 15, 127);  send(-128, 1); drain();
    log_at("t2_512", base, 512);
    log_at("t2_sat_hi", base + 1, 524287);
    log_at("t2_sat_lo", base + 2, -524288);

    // T3: floor versus rounding of half LSB
    base = out_log.size();
    set_cfg(32'h8000, 0, 0);
    pulse_load();
    send(1, 0); send(-1, 0);
    drain();
`ifdef DEQUANT_ROUND_EN
    log_at("t3_pos", base, 1);
    log_at("t3_neg", base + 1, 0);
`else
    log_at("t3_pos", base, 0);
    log_at("t3_neg", base + 1, -1);
`endif

    // T4: backpressure in the middle of a continuous stream
    lat_check = 0;
    set_cfg(32'h8000, 1, 0);
    pulse_load();
    vals = '{5, -6, 7, -8, 9, -10, 11, -12};
    base = out_log.size();
    sent = 0;
    blocked = 0;
    for (int c = 0; c < 60 && sent < 8; c++) begin
      out_ready = !(c >= 4 && c < 9);
      in_valid = 1'b1;
      tmp = vals[sent];
      x_i = tmp[7:0];
      @(negedge clk);
      if (in_ready) sent++;
      else if (!out_ready) blocked = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("t4_sent", sent, 8);
    chk("t4_in_ready_dropped", blocked, 1);
    chk("t4_count", out_log.size() - base, 8);
    for (int i = 0; i < 8; i++) log_at("t4_order", base + i, vals[i]);

    // T5: config update with two samples in flight
    base = out_log.size();
    send(20, 0); send(-40, 0);
    set_cfg(32'h4000, 1, 0);
    cfg_load = 1'b1;
    @(negedge clk);
    chk("t5_busy_at_load", busy, 1);
    @(posedge clk); #1;
    cfg_load = 1'b0;
    in_valid = 1'b1;
    x_i = 8'sd64;
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (busy) chk("t5_blocked_while_busy", in_ready, 0);
      if (in_ready) begin
        chk("t5_accept_idle", busy, 0);
        got = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("t5_accepted", got, 1);
    drain();
    log_at("t5_old_a", base, 20);
    log_at("t5_old_b", base + 1, -40);
    log_at("t5_new", base + 2, 32);

    // T6: reset with three samples stalled in the pipe
    out_ready = 1'b0;
    base = out_log.size();
    send(3, 0); send(4, 0); send(5, 0);
    nrst = 1'b1;
    @(posedge clk); #1;
    nrst = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_wx", wx_o, 0);
    chk("t6_busy", busy, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("t6_nothing_emitted", out_log.size(), base);
    set_cfg(32'h8000, 1, 0);
    pulse_load();
    send(-7, 0);
    drain();
    log_at("t6_after_reset", base, -7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=0", checks);
    $fatal(1, "timeout");
  end

endmodule
